// File: rtl/fibonacci_index_if.sv
// Handshake bundle for the Fibonacci index classifier.
// Input value channel plus result channel, both valid/ready.
interface fibonacci_index_if #(
    parameter int N  = 13,
    parameter int IW = 5
);
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  value;
    logic          out_valid;
    logic          out_ready;
    logic          is_fib;
    logic [IW-1:0] index;

    modport master (
        output in_valid, value, out_ready,
        input  in_ready, out_valid, is_fib, index
    );

    modport slave (
        input  in_valid, value, out_ready,
        output in_ready, out_valid, is_fib, index
    );
endinterface

// File: rtl/fibonacci_index.sv
// Classifies an N-bit value as a Fibonacci number and reports its index.
// Regenerates the sequence one term per cycle until it reaches the value.
module fibonacci_index #(
    parameter int N  = 13,
    parameter int IW = 5
) (
    input logic              clk,
    input logic              reset_n,
    fibonacci_index_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_t;

    state_t        state;
    logic [N-1:0]  v;
    logic [N:0]    a;
    logic [N:0]    b;
    logic [IW-1:0] k;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          is_fib_q;
    logic [IW-1:0] index_q;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.is_fib    = is_fib_q;
    assign bus.index     = index_q;

    // Control FSM, sequence terms and registered result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            v           <= '0;
            a           <= '0;
            b           <= '0;
            k           <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            is_fib_q    <= 1'b0;
            index_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!in_ready_q) begin
                        in_ready_q <= 1'b1;
                    end else if (bus.in_valid) begin
                        v          <= bus.value;
                        a          <= '0;
                        b          <= (N+1)'(1);
                        k          <= '0;
                        in_ready_q <= 1'b0;
                        state      <= SEARCH;
                    end
                end
                SEARCH: begin
                    // b may wrap on the final step; it is never used then.
                    if (a >= {1'b0, v}) begin
                        is_fib_q    <= (a == {1'b0, v});
                        index_q     <= k;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        a <= b;
                        b <= a + b;
                        k <= k + IW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
